// File: rtl/serial_link_port_if.sv
// IO register bus seen by serial_link_port: address plus active-low write and read strobes.
// The data bus is a separate inout port on the responder.
//   master : drives address and strobes (bus router / testbench)
//   slave  : samples address and strobes (register block)
interface serial_link_port_if;
  logic [15:0] I_ADDR_BUS;
  logic        I_WE_BUS_L;
  logic        I_RE_BUS_L;

  modport master (output I_ADDR_BUS, output I_WE_BUS_L, output I_RE_BUS_L);
  modport slave  (input  I_ADDR_BUS, input  I_WE_BUS_L, input  I_RE_BUS_L);
endinterface

// File: rtl/serial_link_port.sv
// Game Boy serial link port: SB (data) and SC (control) registers on the IO bus, plus the
// 8-bit shift exchange with a link partner using the internal or an external serial clock.
// Ports:
//   I_CLK, I_SYNC_RESET : system clock, synchronous active-high reset
//   bus                 : IO bus address and read/write strobes (slave modport)
//   IO_DATA_BUS         : IO bus data, driven only during an addressed read
//   I_SIN, I_SCLK_EXT   : serial data and external clock from partner (asynchronous)
//   O_SOUT, O_SCLK      : serial data out, internal serial clock (idles high)
//   O_SCLK_OE           : high when this end is clock master
//   O_SERIAL_INT        : one-cycle pulse when a transfer completes
//   O_SB                : current SB contents
module serial_link_port #(
  parameter logic [15:0] SB_ADDR      = 16'hFF01,
  parameter logic [15:0] SC_ADDR      = 16'hFF02,
  parameter int unsigned CLK_DIV_HALF = 256,
  parameter int unsigned DIV_SIZE     = 9
) (
  input  logic                 I_CLK,
  input  logic                 I_SYNC_RESET,
  serial_link_port_if.slave    bus,
  inout  wire  [7:0]           IO_DATA_BUS,
  input  logic                 I_SIN,
  input  logic                 I_SCLK_EXT,
  output logic                 O_SOUT,
  output logic                 O_SCLK,
  output logic                 O_SCLK_OE,
  output logic                 O_SERIAL_INT,
  output logic [7:0]           O_SB
);

  localparam logic [DIV_SIZE-1:0] DivLast = DIV_SIZE'(CLK_DIV_HALF - 1);

  typedef enum logic [2:0] {StIdle, StIntLow, StIntHigh, StExtWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [7:0]          sb_q, sb_d;
  logic                start_q, start_d;
  logic                clksel_q, clksel_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DIV_SIZE-1:0] div_q, div_d;
  logic                sout_q, sout_d;
  // [0],[1] synchronize the external clock; [2] is the previous synchronized value
  logic [2:0]          sclk_sync_q, sclk_sync_d;
  logic [1:0]          sin_sync_q, sin_sync_d;

  logic       sb_we, sc_we, sb_re, sc_re;
  logic       sclk_rise, sclk_fall;
  logic       shift_en, shift_bit;
  logic [7:0] wdata, rdata;

  assign sb_we = !bus.I_WE_BUS_L && (bus.I_ADDR_BUS == SB_ADDR);
  assign sc_we = !bus.I_WE_BUS_L && (bus.I_ADDR_BUS == SC_ADDR);
  assign sb_re = !bus.I_RE_BUS_L && (bus.I_ADDR_BUS == SB_ADDR);
  assign sc_re = !bus.I_RE_BUS_L && (bus.I_ADDR_BUS == SC_ADDR);

  assign wdata       = IO_DATA_BUS;
  assign rdata       = sb_re ? sb_q : {start_q, 6'b111111, clksel_q};
  assign IO_DATA_BUS = (sb_re || sc_re) ? rdata : 8'hzz;

  assign sclk_rise = sclk_sync_q[1] && !sclk_sync_q[2];
  assign sclk_fall = !sclk_sync_q[1] && sclk_sync_q[2];

  always_comb begin
    state_d     = state_q;
    sb_d        = sb_q;
    start_d     = start_q;
    clksel_d    = clksel_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    sout_d      = sout_q;
    sclk_sync_d = {sclk_sync_q[1:0], I_SCLK_EXT};
    sin_sync_d  = {sin_sync_q[0], I_SIN};
    shift_en    = 1'b0;
    shift_bit   = 1'b0;

    unique case (state_q)
      StIdle: ;
      StIntLow: begin
        if (div_q == DivLast) begin
          div_d     = '0;
          shift_en  = 1'b1;
          shift_bit = I_SIN;
          state_d   = StIntHigh;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StIntHigh: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (cnt_q == 4'd8) begin
            state_d = StDone;
          end else begin
            sout_d  = sb_q[7];
            state_d = StIntLow;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StExtWait: begin
        if (sclk_fall) sout_d = sb_q[7];
        if (sclk_rise) begin
          shift_en  = 1'b1;
          shift_bit = sin_sync_q[1];
          if (cnt_q == 4'd7) state_d = StDone;
        end
      end
      StDone: begin
        start_d = 1'b0;
        sout_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (shift_en) begin
      sb_d  = {sb_q[6:0], shift_bit};
      cnt_d = cnt_q + 4'd1;
    end

    // A bus write to SB replaces a shift in the same cycle; the bit still counts.
    if (sb_we) sb_d = wdata;

    // SC writes override everything the FSM decided this cycle, including completion.
    if (sc_we) begin
      clksel_d = wdata[0];
      start_d  = wdata[7];
      if (wdata[7]) begin
        cnt_d   = '0;
        div_d   = '0;
        sout_d  = sb_q[7];
        state_d = wdata[0] ? StIntLow : StExtWait;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RESET) begin
      state_q     <= StIdle;
      sb_q        <= '0;
      start_q     <= 1'b0;
      clksel_q    <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
      sout_q      <= 1'b1;
      sclk_sync_q <= 3'b111;
      sin_sync_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      start_q     <= start_d;
      clksel_q    <= clksel_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      sout_q      <= sout_d;
      sclk_sync_q <= sclk_sync_d;
      sin_sync_q  <= sin_sync_d;
    end
  end

  assign O_SOUT       = sout_q;
  assign O_SCLK       = (state_q != StIntLow);
  assign O_SCLK_OE    = clksel_q;
  assign O_SERIAL_INT = (state_q == StDone) && !sc_we;
  assign O_SB         = sb_q;

endmodule

// File: tb/tb_serial_link_port.sv
module tb_serial_link_port;

  localparam int unsigned N = 4;
  localparam logic [15:0] SbA = 16'hFF01;
  localparam logic [15:0] ScA = 16'hFF02;

  logic       I_CLK = 1'b0;
  logic       I_SYNC_RESET = 1'b1;
  logic       I_SIN = 1'b1;
  logic       I_SCLK_EXT = 1'b1;
  logic       O_SOUT, O_SCLK, O_SCLK_OE, O_SERIAL_INT;
  logic [7:0] O_SB;

  logic       tb_drv = 1'b0;
  logic [7:0] tb_wdata = 8'h00;
  tri1  [7:0] data_bus;
  assign data_bus = tb_drv ? tb_wdata : 8'hzz;

  serial_link_port_if bus_if ();

  serial_link_port #(.CLK_DIV_HALF(N), .DIV_SIZE(9)) dut (
    .I_CLK       (I_CLK),
    .I_SYNC_RESET(I_SYNC_RESET),
    .bus         (bus_if),
    .IO_DATA_BUS (data_bus),
    .I_SIN       (I_SIN),
    .I_SCLK_EXT  (I_SCLK_EXT),
    .O_SOUT      (O_SOUT),
    .O_SCLK      (O_SCLK),
    .O_SCLK_OE   (O_SCLK_OE),
    .O_SERIAL_INT(O_SERIAL_INT),
    .O_SB        (O_SB)
  );

  always #5 I_CLK = ~I_CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
    @(negedge I_CLK);
    bus_if.I_ADDR_BUS = addr;
    tb_wdata          = d;
    tb_drv            = 1'b1;
    bus_if.I_WE_BUS_L = 1'b0;
    @(posedge I_CLK);
    #1;
    bus_if.I_WE_BUS_L = 1'b1;
    tb_drv            = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] d);
    @(negedge I_CLK);
    bus_if.I_ADDR_BUS = addr;
    bus_if.I_RE_BUS_L = 1'b0;
    #1;
    d = data_bus;
    bus_if.I_RE_BUS_L = 1'b1;
  endtask

  // Link observer and partner: the partner presents its next bit on each falling O_SCLK.
  logic       sout_seen[$];
  int         low_lens[$];
  int         low_run, nfall, int_cnt, int_at, cyc;
  logic       prev_sclk;
  logic [7:0] partner;

  task automatic reset_obs();
    sout_seen.delete();
    low_lens.delete();
    low_run   = 0;
    nfall     = 0;
    int_cnt   = 0;
    int_at    = -1;
    cyc       = 0;
    prev_sclk = 1'b1;
  endtask

  task automatic sample();
    if (prev_sclk && !O_SCLK) begin
      sout_seen.push_back(O_SOUT);
      if (nfall < 8) I_SIN = partner[7 - nfall];
      nfall++;
    end
    if (!O_SCLK) low_run++;
    else if (!prev_sclk) begin
      low_lens.push_back(low_run);
      low_run = 0;
    end
    if (O_SERIAL_INT) begin
      int_cnt++;
      int_at = cyc;
    end
    prev_sclk = O_SCLK;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge I_CLK);
      #1;
      cyc++;
      sample();
    end
  endtask

  function automatic logic [7:0] sout_byte();
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8 && k < sout_seen.size(); k++) b = {b[6:0], sout_seen[k]};
    return b;
  endfunction

  task automatic start_int(input logic [7:0] sb0, input logic [7:0] pat);
    reset_obs();
    partner = pat;
    bus_write(SbA, sb0);
    bus_write(ScA, 8'h81);
    sample();
  endtask

  // Reference: an internal transfer sends SB MSB-first, ends with SB equal to the partner
  // byte, and raises the interrupt 16 half-periods after the start write.
  task automatic int_xfer(input logic [7:0] sb0, input logic [7:0] pat);
    logic [7:0] rd;
    start_int(sb0, pat);
    run_cycles(80);
    check_eq("int_nbits", sout_seen.size(), 8);
    check_eq("int_sout", sout_byte(), sb0);
    check_eq("int_npulse", low_lens.size(), 8);
    foreach (low_lens[k]) check_eq("int_pulse_len", low_lens[k], N);
    check_eq("int_count", int_cnt, 1);
    check_eq("int_time", int_at, 16 * N);
    check_eq("int_sb", O_SB, pat);
    check_eq("int_sout_idle", O_SOUT, 1'b1);
    check_eq("int_oe", O_SCLK_OE, 1'b1);
    bus_read(ScA, rd);
    check_eq("int_sc", rd, 8'h7F);
  endtask

  task automatic ext_xfer(input logic [7:0] sb0, input logic [7:0] pat);
    logic [7:0] rd;
    reset_obs();
    partner = pat;
    bus_write(SbA, sb0);
    bus_write(ScA, 8'h80);
    run_cycles(30);
    check_eq("ext_idle_sb", O_SB, sb0);
    check_eq("ext_idle_int", int_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      I_SCLK_EXT = 1'b0;
      I_SIN      = pat[7 - k];
      run_cycles(9);
      check_eq("ext_sout", O_SOUT, sb0[7 - k]);
      run_cycles(1);
      I_SCLK_EXT = 1'b1;
      run_cycles(10);
    end
    run_cycles(5);
    check_eq("ext_sb", O_SB, pat);
    check_eq("ext_int", int_cnt, 1);
    check_eq("ext_oe", O_SCLK_OE, 1'b0);
    check_eq("ext_nsclk", low_lens.size() + nfall, 0);
    bus_read(ScA, rd);
    check_eq("ext_sc", rd, 8'h7E);
  endtask

  initial begin
    logic [7:0] rd, sb0, pat, w;
    bus_if.I_ADDR_BUS = 16'h0000;
    bus_if.I_WE_BUS_L = 1'b1;
    bus_if.I_RE_BUS_L = 1'b1;
    repeat (3) @(posedge I_CLK);
    @(negedge I_CLK);
    I_SYNC_RESET = 1'b0;

    // Reset state
    check_eq("rst_sout", O_SOUT, 1'b1);
    check_eq("rst_sclk", O_SCLK, 1'b1);
    check_eq("rst_oe", O_SCLK_OE, 1'b0);
    check_eq("rst_int", O_SERIAL_INT, 1'b0);
    bus_read(ScA, rd);
    check_eq("rst_sc", rd, 8'h7E);
    bus_read(SbA, rd);
    check_eq("rst_sb", rd, 8'h00);
    bus_read(16'hFF03, rd);
    check_eq("bus_z_unaddr", rd, 8'hFF);
    bus_if.I_ADDR_BUS = SbA;
    #1;
    check_eq("bus_z_no_re", data_bus, 8'hFF);

    // Internal transfers
    int_xfer(8'hA5, 8'h3C);
    for (int t = 0; t < 2; t++) int_xfer(8'($urandom), 8'($urandom));

    // External transfers
    ext_xfer(8'h0F, 8'hFF);
    ext_xfer(8'($urandom), 8'($urandom));

    // Abort after three shifted bits
    sb0 = 8'($urandom);
    pat = 8'($urandom);
    start_int(sb0, pat);
    run_cycles(22);
    bus_write(ScA, 8'h01);
    cyc++;
    sample();
    run_cycles(40);
    check_eq("abort_int", int_cnt, 0);
    check_eq("abort_npulse", low_lens.size(), 3);
    check_eq("abort_sclk", O_SCLK, 1'b1);
    check_eq("abort_sb", O_SB, 8'((sb0 << 3) | (pat >> 5)));
    bus_read(ScA, rd);
    check_eq("abort_sc", rd, 8'h7F);

    // Write/shift collision on the third shift edge
    sb0 = 8'($urandom);
    pat = 8'($urandom);
    w   = 8'($urandom);
    start_int(sb0, pat);
    run_cycles(19);
    bus_write(SbA, w);
    cyc++;
    sample();
    check_eq("coll_sb_now", O_SB, w);
    run_cycles(60);
    check_eq("coll_int", int_cnt, 1);
    check_eq("coll_time", int_at, 16 * N);
    check_eq("coll_sout", sout_byte(), (sb0 & 8'hE0) | (w >> 3));
    check_eq("coll_sb", O_SB, 8'((w << 5) | (pat & 8'h1F)));

    // Reset mid-transfer
    start_int(8'hFF, 8'hFF);
    run_cycles(10);
    @(negedge I_CLK);
    I_SYNC_RESET = 1'b1;
    @(posedge I_CLK);
    #1;
    check_eq("mrst_sout", O_SOUT, 1'b1);
    check_eq("mrst_sclk", O_SCLK, 1'b1);
    check_eq("mrst_oe", O_SCLK_OE, 1'b0);
    check_eq("mrst_int", O_SERIAL_INT, 1'b0);
    check_eq("mrst_sb", O_SB, 8'h00);
    @(negedge I_CLK);
    I_SYNC_RESET = 1'b0;
    reset_obs();
    run_cycles(80);
    check_eq("mrst_no_int", int_cnt, 0);
    check_eq("mrst_no_sclk", low_lens.size() + nfall, 0);
    bus_read(ScA, rd);
    check_eq("mrst_sc", rd, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
